// File: rtl/nes_cpu_bus_pkg.sv
// Shared types and memory-map constants for the NES CPU bus decoder and its OAM DMA engine.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_PPU,
    SRC_IO,
    SRC_PRG
  } bus_src_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_ALIGN,
    DMA_RD,
    DMA_WR
  } dma_state_t;

  localparam logic [15:0] RAM_LIMIT    = 16'h1FFF;
  localparam logic [15:0] PPU_BASE     = 16'h2000;
  localparam logic [15:0] PPU_LIMIT    = 16'h3FFF;
  localparam logic [15:0] IO_BASE      = 16'h4000;
  localparam logic [15:0] IO_LIMIT     = 16'h401F;
  localparam logic [15:0] PRG_BASE     = 16'h8000;
  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
  localparam logic [2:0]  OAM_DATA_REG = 3'd4;

  // $4014 sits inside the IO window but belongs to the DMA engine, so it decodes as unmapped.
  function automatic bus_src_t decode_src(input logic [15:0] addr);
    bus_src_t src;
    src = SRC_NONE;
    if (addr <= RAM_LIMIT) begin
      src = SRC_RAM;
    end else if (addr >= PPU_BASE && addr <= PPU_LIMIT) begin
      src = SRC_PPU;
    end else if (addr >= IO_BASE && addr <= IO_LIMIT && addr != DMA_REG_ADDR) begin
      src = SRC_IO;
    end else if (addr >= PRG_BASE) begin
      src = SRC_PRG;
    end
    return src;
  endfunction

endpackage

// File: rtl/nes_cpu_bus_if.sv
// CPU-side request/return bus between the 6502 core (master) and the bus decoder (slave).
interface nes_cpu_bus_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        stall;

  modport master (output req, output we, output addr, output wdata,
                  input rdata, input rvalid, input stall);
  modport slave  (input req, input we, input addr, input wdata,
                  output rdata, output rvalid, output stall);
endinterface

// File: rtl/nes_cpu_bus_oam_dma_fsm.sv
// OAM DMA sequencer: after a $4014 write, copies page {page,00..FF} to PPU OAMDATA one byte per RD/WR pair.
module oam_dma_fsm
  import nes_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_page,
  input  logic        i_parity,
  input  logic [7:0]  i_rdata,
  output logic        o_dma_busy,
  output logic        o_dma_rd,
  output logic        o_dma_wr,
  output logic [15:0] o_dma_rd_addr,
  output logic [7:0]  o_dma_wdata
);

  dma_state_t r_state, w_state_n;
  logic [7:0] r_page, w_page_n;
  logic [7:0] r_cnt, w_cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DMA_IDLE;
      r_page  <= 8'h00;
      r_cnt   <= 8'h00;
    end else begin
      r_state <= w_state_n;
      r_page  <= w_page_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // ALIGN leaves on parity 0; entering on parity 1 therefore costs exactly one extra cycle.
  always_comb begin
    w_state_n = r_state;
    w_page_n  = r_page;
    w_cnt_n   = r_cnt;
    case (r_state)
      DMA_IDLE: begin
        if (i_start) begin
          w_state_n = DMA_ALIGN;
          w_page_n  = i_page;
          w_cnt_n   = 8'h00;
        end
      end
      DMA_ALIGN: begin
        if (!i_parity) w_state_n = DMA_RD;
      end
      DMA_RD: begin
        w_state_n = DMA_WR;
      end
      DMA_WR: begin
        w_cnt_n   = r_cnt + 8'd1;
        w_state_n = (r_cnt == 8'hFF) ? DMA_IDLE : DMA_RD;
      end
      default: w_state_n = DMA_IDLE;
    endcase
  end

  assign o_dma_busy    = (r_state != DMA_IDLE);
  assign o_dma_rd      = (r_state == DMA_RD);
  assign o_dma_wr      = (r_state == DMA_WR);
  assign o_dma_rd_addr = {r_page, r_cnt};
  assign o_dma_wdata   = i_rdata;

endmodule

// File: rtl/nes_cpu_bus.sv
// NES CPU memory-map decoder: chip selects, 1-cycle aligned read-return mux, open bus and OAM DMA host.
module nes_cpu_bus
  import nes_bus_pkg::*;
#(
  parameter int RAM_AW      = 11,
  parameter bit OPEN_BUS_EN = 1'b1,
  parameter bit DMA_EN      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  nes_cpu_bus_if.slave      cpu,
  output logic              o_ram_ena,
  output logic              o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [7:0]        o_ram_wdata,
  input  logic [7:0]        i_ram_rdata,
  output logic              o_ppu_cs,
  output logic              o_ppu_we,
  output logic [2:0]        o_ppu_reg,
  output logic [7:0]        o_ppu_wdata,
  input  logic [7:0]        i_ppu_rdata,
  output logic              o_io_cs,
  output logic              o_io_we,
  output logic [4:0]        o_io_addr,
  input  logic [7:0]        i_io_rdata,
  output logic              o_prg_ena,
  output logic [14:0]       o_prg_addr,
  input  logic [7:0]        i_prg_data
);

  logic        w_cpu_acc, w_acc_rd, w_acc_wr, w_dma_start;
  logic [15:0] w_acc_addr;
  bus_src_t    w_src;
  logic        w_dma_busy, w_dma_rd, w_dma_wr;
  logic [15:0] w_dma_rd_addr;
  logic [7:0]  w_dma_wdata, w_ret_data;
  bus_src_t    r_tag_src;
  logic        r_tag_cpu;
  logic [7:0]  r_open_bus;
  logic        r_parity;

  assign w_cpu_acc = cpu.req & ~w_dma_busy & ~rst;

  // A DMA read borrows the CPU decode path so it sees RAM, ROM, PPU and open bus exactly as the CPU would.
  always_comb begin
    w_acc_addr = cpu.addr;
    w_acc_rd   = w_cpu_acc & ~cpu.we;
    w_acc_wr   = w_cpu_acc & cpu.we;
    if (w_dma_rd) begin
      w_acc_addr = w_dma_rd_addr;
      w_acc_rd   = 1'b1;
      w_acc_wr   = 1'b0;
    end
  end

  assign w_src       = decode_src(w_acc_addr);
  assign w_dma_start = DMA_EN && w_acc_wr && (w_acc_addr == DMA_REG_ADDR);

  assign o_ram_ena   = (w_acc_rd | w_acc_wr) && (w_src == SRC_RAM);
  assign o_ram_we    = w_acc_wr && (w_src == SRC_RAM);
  assign o_ram_addr  = w_acc_addr[RAM_AW-1:0];
  assign o_ram_wdata = cpu.wdata;
  assign o_ppu_cs    = ((w_acc_rd | w_acc_wr) && (w_src == SRC_PPU)) || w_dma_wr;
  assign o_ppu_we    = (w_acc_wr && (w_src == SRC_PPU)) || w_dma_wr;
  assign o_ppu_reg   = w_dma_wr ? OAM_DATA_REG : w_acc_addr[2:0];
  assign o_ppu_wdata = w_dma_wr ? w_dma_wdata : cpu.wdata;
  assign o_io_cs     = (w_acc_rd | w_acc_wr) && (w_src == SRC_IO);
  assign o_io_we     = w_acc_wr && (w_src == SRC_IO);
  assign o_io_addr   = w_acc_addr[4:0];
  assign o_prg_ena   = w_acc_rd && (w_src == SRC_PRG);
  assign o_prg_addr  = w_acc_addr[14:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_src  <= SRC_NONE;
      r_tag_cpu  <= 1'b0;
      r_open_bus <= 8'h00;
      r_parity   <= 1'b0;
    end else begin
      r_tag_src <= w_acc_rd ? w_src : SRC_NONE;
      r_tag_cpu <= w_cpu_acc & ~cpu.we;
      r_parity  <= ~r_parity;
      if (r_tag_cpu) r_open_bus <= w_ret_data;
    end
  end

  always_comb begin
    w_ret_data = OPEN_BUS_EN ? r_open_bus : 8'h00;
    case (r_tag_src)
      SRC_RAM: w_ret_data = i_ram_rdata;
      SRC_PPU: w_ret_data = i_ppu_rdata;
      SRC_IO:  w_ret_data = i_io_rdata;
      SRC_PRG: w_ret_data = i_prg_data;
      default: ;
    endcase
  end

  assign cpu.rdata  = r_tag_cpu ? w_ret_data : 8'h00;
  assign cpu.rvalid = r_tag_cpu;
  assign cpu.stall  = w_dma_busy;

  oam_dma_fsm u_dma (
    .clk           (clk),
    .rst           (rst),
    .i_start       (w_dma_start),
    .i_page        (cpu.wdata),
    .i_parity      (r_parity),
    .i_rdata       (w_ret_data),
    .o_dma_busy    (w_dma_busy),
    .o_dma_rd      (w_dma_rd),
    .o_dma_wr      (w_dma_wr),
    .o_dma_rd_addr (w_dma_rd_addr),
    .o_dma_wdata   (w_dma_wdata)
  );

endmodule

// File: tb/tb_nes_cpu_bus.sv
// Bench for nes_cpu_bus: directed CPU accesses scored by a read-return monitor, plus OAM DMA and reset-abort checks.
module tb_nes_cpu_bus;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nes_cpu_bus_if bus();

  logic        ramEna, ramWe, ppuCs, ppuWe, ioCs, ioWe, prgEna;
  logic [10:0] ramAddr;
  logic [7:0]  ramWdata, ppuWdata;
  logic [2:0]  ppuReg;
  logic [4:0]  ioAddr;
  logic [14:0] prgAddr;
  logic [7:0]  ramRdata, ppuRdata, ioRdata, prgData;

  nes_cpu_bus #(.RAM_AW(11), .OPEN_BUS_EN(1'b1), .DMA_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu         (bus),
    .o_ram_ena   (ramEna),
    .o_ram_we    (ramWe),
    .o_ram_addr  (ramAddr),
    .o_ram_wdata (ramWdata),
    .i_ram_rdata (ramRdata),
    .o_ppu_cs    (ppuCs),
    .o_ppu_we    (ppuWe),
    .o_ppu_reg   (ppuReg),
    .o_ppu_wdata (ppuWdata),
    .i_ppu_rdata (ppuRdata),
    .o_io_cs     (ioCs),
    .o_io_we     (ioWe),
    .o_io_addr   (ioAddr),
    .i_io_rdata  (ioRdata),
    .o_prg_ena   (prgEna),
    .o_prg_addr  (prgAddr),
    .i_prg_data  (prgData)
  );

  always #5 clk = ~clk;

  int         testsRun = 0;
  int         testsFailed = 0;
  int         cycleCount = 0;
  logic       tbParity;
  logic [7:0] expDataQ[$];
  int         expCycleQ[$];
  logic [7:0] dmaBytes[$];
  bit         captureOn = 1'b0;
  logic [7:0] ramMem[2048];

  // Peripheral models, each returning read data one cycle after its enable.
  initial for (int i = 0; i < 2048; i++) ramMem[i] = 8'h00;

  always @(posedge clk) begin
    if (ramEna) begin
      if (ramWe) ramMem[ramAddr] <= ramWdata;
      else       ramRdata <= ramMem[ramAddr];
    end
    if (ppuCs && !ppuWe) ppuRdata <= 8'hC0 | {5'b0, ppuReg};
    if (ioCs && !ioWe)   ioRdata  <= 8'h47 + {3'b0, ioAddr};
    if (prgEna)          prgData  <= (prgAddr == 15'h7FFC) ? 8'h34 : (prgAddr[7:0] ^ 8'hA5);
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) tbParity <= 1'b0;
    else     tbParity <= ~tbParity;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every rvalid must match the oldest expected read, in the expected cycle.
  always @(negedge clk) begin : monitor
    logic [7:0] expData;
    int         expCycle;
    if (!rst) begin
      if (bus.rvalid) begin
        if (expDataQ.size() == 0) begin
          checkOutput("unexpectedRvalid", 32'd1, 32'd0);
        end else begin
          expData  = expDataQ.pop_front();
          expCycle = expCycleQ.pop_front();
          checkOutput("readData", 32'(bus.rdata), 32'(expData));
          checkOutput("readLatency", 32'(cycleCount), 32'(expCycle));
        end
      end else if (expCycleQ.size() != 0 && expCycleQ[0] <= cycleCount) begin
        checkOutput("missingRvalid", 32'd0, 32'd1);
        void'(expDataQ.pop_front());
        void'(expCycleQ.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && captureOn && ppuCs && ppuWe && ppuReg == 3'd4) dmaBytes.push_back(ppuWdata);
  end

  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                               input logic [7:0] expData);
    @(posedge clk);
    #1;
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = addr;
    bus.wdata = wdata;
    if (!we) begin
      expDataQ.push_back(expData);
      expCycleQ.push_back(cycleCount + 1);
    end
  endtask

  task automatic busIdle();
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic startDma(input logic wantParity, output int stallCycles, output logic writeParity);
    @(posedge clk);
    #1;
    if (tbParity !== wantParity) begin
      @(posedge clk);
      #1;
    end
    writeParity = tbParity;
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 16'h4014;
    bus.wdata = 8'h02;
    #1;
    checkOutput("dmaWriteNoSelect", 32'({ioCs, ppuCs, ramEna, prgEna}), 32'd0);
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bus.we  = 1'b0;
    stallCycles = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (bus.stall) stallCycles++;
      else break;
    end
  endtask

  task automatic checkDma(input string name);
    int errs;
    errs = 0;
    checkOutput({name, "Count"}, 32'(dmaBytes.size()), 32'd256);
    for (int i = 0; i < dmaBytes.size() && i < 256; i++) begin
      if (dmaBytes[i] !== 8'(i * 3 + 7)) errs++;
    end
    checkOutput({name, "DataErrors"}, 32'(errs), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int   stallCycles;
    logic writeParity;
    logic stallSeen;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 16'h0000;
    bus.wdata = 8'h00;

    #12;
    checkOutput("resetSelects", 32'({ramEna, ramWe, ppuCs, ppuWe, ioCs, ioWe, prgEna}), 32'd0);
    checkOutput("resetCpu", 32'({bus.rvalid, bus.stall, bus.rdata}), 32'd0);
    #20;
    rst = 1'b0;

    applyStimulus(1'b0, 16'hFFFC, 8'h00, 8'h34);
    #1 checkOutput("prgDecode", 32'({prgEna, prgAddr}), 32'({1'b1, 15'h7FFC}));
    applyStimulus(1'b1, 16'h0801, 8'hAA, 8'h00);
    #1 checkOutput("ramWriteMirror", 32'({ramEna, ramWe, ramAddr, ramWdata}), 32'({1'b1, 1'b1, 11'h001, 8'hAA}));
    applyStimulus(1'b0, 16'h0001, 8'h00, 8'hAA);
    applyStimulus(1'b0, 16'h2002, 8'h00, 8'hC2);
    #1 checkOutput("ppuReg2002", 32'({ppuCs, ppuWe, ppuReg}), 32'({1'b1, 1'b0, 3'd2}));
    applyStimulus(1'b0, 16'h3FFA, 8'h00, 8'hC2);
    #1 checkOutput("ppuReg3FFA", 32'({ppuCs, ppuWe, ppuReg}), 32'({1'b1, 1'b0, 3'd2}));
    applyStimulus(1'b0, 16'hFFFC, 8'h00, 8'h34);
    applyStimulus(1'b0, 16'h4015, 8'h00, 8'h5C);
    #1 checkOutput("ioDecode", 32'({ioCs, ioWe, ioAddr}), 32'({1'b1, 1'b0, 5'h15}));
    applyStimulus(1'b0, 16'h6000, 8'h00, 8'h5C);
    #1 checkOutput("unmappedNoSelect", 32'({ramEna, ppuCs, ioCs, prgEna}), 32'd0);
    applyStimulus(1'b1, 16'h8000, 8'h55, 8'h00);
    #1 checkOutput("romWriteDropped", 32'({ramEna, ramWe, ppuCs, ppuWe, ioCs, ioWe, prgEna}), 32'd0);

    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 16'h0200 + 16'(i), 8'(i * 3 + 7), 8'h00);
    busIdle();

    dmaBytes.delete();
    captureOn = 1'b1;
    startDma(1'b0, stallCycles, writeParity);
    captureOn = 1'b0;
    checkOutput("dmaStallEven", 32'(stallCycles), writeParity ? 32'd513 : 32'd514);
    checkDma("dmaEven");

    dmaBytes.delete();
    captureOn = 1'b1;
    startDma(1'b1, stallCycles, writeParity);
    captureOn = 1'b0;
    checkOutput("dmaStallOdd", 32'(stallCycles), writeParity ? 32'd513 : 32'd514);
    checkDma("dmaOdd");

    applyStimulus(1'b0, 16'h0203, 8'h00, 8'h10);
    busIdle();

    dmaBytes.delete();
    captureOn = 1'b1;
    applyStimulus(1'b1, 16'h4014, 8'h02, 8'h00);
    busIdle();
    for (int i = 0; i < 1000 && dmaBytes.size() < 100; i++) @(posedge clk);
    checkOutput("dmaReach100", 32'(dmaBytes.size() >= 100), 32'd1);
    #3;
    rst = 1'b1;
    captureOn = 1'b0;
    #1 checkOutput("rstAbort", 32'({bus.stall, ppuCs}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stallSeen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      stallSeen = stallSeen | bus.stall;
    end
    checkOutput("idleAfterRst", 32'(stallSeen), 32'd0);

    applyStimulus(1'b0, 16'h6000, 8'h00, 8'h00);
    applyStimulus(1'b0, 16'h0201, 8'h00, 8'h0A);
    busIdle();
    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(expDataQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
